// File: rtl/skid_crd_pkg.sv
// Shared sizing helpers and beat layout for the credit-style skid FIFO.
package skid_crd_pkg;

  localparam int MAX_DEPTH = 64;
  localparam int MAX_N     = 64;

  // Width of a fill counter able to represent 0..depth inclusive.
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Flattened beat width: data bytes, one keep bit per byte, and last.
  function automatic int beat_w(input int n);
    return n * 8 + n + 1;
  endfunction

  // Widest possible beat; narrower instances use the low bytes/keep bits.
  typedef struct packed {
    logic [MAX_N*8-1:0] data;
    logic [MAX_N-1:0]   keep;
    logic               last;
  } beat_max_t;

endpackage

// File: rtl/skid_crd_ram.sv
// Beat storage: synchronous write port, asynchronous read port, no reset.
module skid_crd_ram #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 37
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the incoming beat into its slot.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/skid_crd_fifo.sv
// Elastic AXI-Stream buffer with registered ready/valid, null-beat discard,
// fill level and half-full flag. The output register counts as one of the
// depth slots; the RAM holds everything behind it.
module skid_crd_fifo
  import skid_crd_pkg::*;
#(
  parameter int n         = 4,
  parameter int depth     = 4,
  parameter bit drop_null = 1'b1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [n*8-1:0]              in_tdata,
  input  logic [n-1:0]                in_tkeep,
  input  logic                        in_tlast,
  input  logic                        in_tvalid,
  output logic                        in_tready,
  output logic [n*8-1:0]              out_tdata,
  output logic [n-1:0]                out_tkeep,
  output logic                        out_tlast,
  output logic                        out_tvalid,
  input  logic                        out_tready,
  output logic [$clog2(depth+1)-1:0]  fill_level,
  output logic                        flag_hf
);

  localparam int NB = n * 8;
  localparam int BW = beat_w(n);
  localparam int AW = $clog2(depth);
  localparam int FW = fill_w(depth);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] ram_cnt_q, ram_cnt_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          in_tready_q, in_tready_d;
  logic          out_valid_q, out_valid_d;
  logic [BW-1:0] out_beat_q, out_beat_d;
  logic          hf_q, hf_d;

  logic          push, pop, is_null, store;
  logic          out_load, ram_rd, bypass, ram_wr;
  logic [BW-1:0] in_beat, ram_rdata;

  assign in_beat = {in_tlast, in_tkeep, in_tdata};
  assign push    = in_tvalid & in_tready_q;
  assign pop     = out_valid_q & out_tready;
  assign is_null = drop_null & (in_tkeep == '0) & ~in_tlast;
  assign store   = push & ~is_null;

  // The output register refills whenever it is empty or being drained.
  // An empty RAM lets a fresh beat go straight into it for 1-cycle latency.
  assign out_load = ~out_valid_q | pop;
  assign ram_rd   = out_load & (ram_cnt_q != '0);
  assign bypass   = out_load & (ram_cnt_q == '0) & store;
  assign ram_wr   = store & ~bypass;

  skid_crd_ram #(
    .DEPTH (depth),
    .AW    (AW),
    .W     (BW)
  ) u_ram (
    .clk     (aclk),
    .we_i    (ram_wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_beat),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Next-state for pointers, counters, output stage and flags.
  always_comb begin
    wr_ptr_d    = ram_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = ram_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ram_cnt_d   = ram_cnt_q + FW'(ram_wr) - FW'(ram_rd);
    fill_d      = fill_q + FW'(store) - FW'(pop);
    out_valid_d = out_valid_q;
    out_beat_d  = out_beat_q;
    if (out_load) begin
      out_valid_d = ram_rd | bypass;
      if (ram_rd)      out_beat_d = ram_rdata;
      else if (bypass) out_beat_d = in_beat;
    end
    in_tready_d = (fill_d < FW'(depth));
    hf_d        = (fill_d >= FW'(depth / 2));
  end

  // State registers; reset discards every held beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      fill_q      <= '0;
      in_tready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
      hf_q        <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      fill_q      <= fill_d;
      in_tready_q <= in_tready_d;
      out_valid_q <= out_valid_d;
      out_beat_q  <= out_beat_d;
      hf_q        <= hf_d;
    end
  end

  assign in_tready  = in_tready_q;
  assign out_tvalid = out_valid_q;
  assign out_tdata  = out_beat_q[NB-1:0];
  assign out_tkeep  = out_beat_q[NB +: n];
  assign out_tlast  = out_beat_q[BW-1];
  assign fill_level = fill_q;
  assign flag_hf    = hf_q;

endmodule

// File: tb/tb_skid_crd_fifo.sv
// Self-checking bench for skid_crd_fifo (n=4, depth=4, drop_null=1).
module tb_skid_crd_fifo;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [31:0]   in_tdata = '0;
  logic [3:0]    in_tkeep = '0;
  logic          in_tlast = 1'b0;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic [31:0]   out_tdata;
  logic [3:0]    out_tkeep;
  logic          out_tlast;
  logic          out_tvalid;
  logic          out_tready = 1'b0;
  logic [2:0]    fill_level;
  logic          flag_hf;

  skid_crd_fifo #(.n(N), .depth(DEPTH), .drop_null(1'b1)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_tdata   (in_tdata),
    .in_tkeep   (in_tkeep),
    .in_tlast   (in_tlast),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tlast  (out_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .fill_level (fill_level),
    .flag_hf    (flag_hf)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: queue of beats the consumer still has to see.
  logic [36:0] q[$];
  logic        m_ready = 1'b0;
  logic        m_push;
  int          max_fill = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, update the model, then compare every output.
  task automatic cycle();
    logic m_pop;
    m_push = in_tvalid && m_ready && aresetn;
    m_pop  = (q.size() > 0) && out_tready && aresetn;
    @(posedge aclk);
    if (!aresetn) begin
      q.delete();
      m_ready = 1'b0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push && !(in_tkeep == 4'h0 && !in_tlast))
        q.push_back({in_tlast, in_tkeep, in_tdata});
      m_ready = (q.size() < DEPTH);
    end
    if (q.size() > max_fill) max_fill = q.size();
    #1;
    chk("in_tready", 64'(in_tready), 64'(m_ready));
    chk("out_tvalid", 64'(out_tvalid), 64'(q.size() > 0));
    chk("fill_level", 64'(fill_level), 64'(q.size()));
    chk("flag_hf", 64'(flag_hf), 64'(q.size() >= DEPTH / 2));
    if (q.size() > 0) begin
      chk("out_tdata", 64'(out_tdata), 64'(q[0][31:0]));
      chk("out_tkeep", 64'(out_tkeep), 64'(q[0][35:32]));
      chk("out_tlast", 64'(out_tlast), 64'(q[0][36]));
    end
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int guard;
    guard = 0;
    in_tdata = d; in_tkeep = k; in_tlast = l; in_tvalid = 1'b1;
    while (!m_ready && guard < 50) begin
      cycle();
      guard++;
    end
    if (guard >= 50) chk("push_timeout", 64'(guard), 64'(0));
    else cycle();
    in_tvalid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    out_tready = 1'b1;
    while (q.size() > 0 && guard < 100) begin
      cycle();
      guard++;
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
    out_tready = 1'b0;
  endtask

  initial begin
    int sent, pause, rdy_cnt, guard;
    logic [31:0] first;

    // Reset held 100 ns with a producer already offering data.
    in_tvalid = 1'b1;
    in_tdata  = "ZZZZ";
    in_tkeep  = 4'hF;
    for (int i = 0; i < 10; i++) cycle();
    aresetn   = 1'b1;
    in_tvalid = 1'b0;
    cycle();
    chk("ready_after_rst", 64'(in_tready), 64'(1));
    chk("fill_after_rst", 64'(fill_level), 64'(0));

    // Fill to full with the consumer stalled.
    out_tready = 1'b0;
    push_beat("0123", 4'hF, 1'b0);
    chk("hf_after_1", 64'(flag_hf), 64'(0));
    push_beat("4567", 4'hF, 1'b0);
    chk("hf_after_2", 64'(flag_hf), 64'(1));
    push_beat("89ab", 4'hF, 1'b0);
    push_beat("cdef", 4'hF, 1'b1);
    chk("full_fill", 64'(fill_level), 64'(4));
    chk("full_ready", 64'(in_tready), 64'(0));

    // One pop from full, then refill and drain in order.
    out_tready = 1'b1;
    cycle();
    out_tready = 1'b0;
    chk("ready_after_pop", 64'(in_tready), 64'(1));
    chk("head_after_pop", 64'(out_tdata), 64'("4567"));
    push_beat("ghij", 4'hF, 1'b1);
    drain();

    // Null-beat discard.
    max_fill = 0;
    push_beat("AAAA", 4'hF, 1'b0);
    push_beat("XXXX", 4'h0, 1'b0);
    push_beat("YYYY", 4'h0, 1'b1);
    chk("null_fill", 64'(fill_level), 64'(2));
    chk("null_head", 64'(out_tdata), 64'("AAAA"));
    out_tready = 1'b1;
    cycle();
    out_tready = 1'b0;
    chk("null_second", 64'({out_tlast, out_tkeep, out_tdata}), 64'({1'b1, 4'h0, 32'("YYYY")}));
    drain();
    chk("null_max_fill", 64'(max_fill <= 2), 64'(1));

    // Random stress: producer pauses and consumer stalls.
    sent = 0; pause = 0; rdy_cnt = 0; guard = 0;
    max_fill = 0;
    while ((sent < 500 || q.size() > 0) && guard < 20000) begin
      if (pause > 0) pause--;
      else if (!in_tvalid && sent < 500) begin
        in_tvalid = 1'b1;
        in_tdata  = $urandom;
        in_tkeep  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
        in_tlast  = 1'($urandom);
      end
      if (sent >= 500) out_tready = 1'b1;
      else if (rdy_cnt == 0) begin
        out_tready = ~out_tready;
        rdy_cnt = out_tready ? $urandom_range(0, 6) : $urandom_range(1, 6);
      end else rdy_cnt--;
      cycle();
      if (m_push) begin
        sent++;
        in_tvalid = 1'b0;
        pause = $urandom_range(0, 3);
      end
      guard++;
    end
    chk("stress_done", 64'(guard < 20000), 64'(1));
    chk("stress_max_fill", 64'(max_fill <= DEPTH), 64'(1));
    out_tready = 1'b0;

    // Mid-stream asynchronous reset with three beats held.
    push_beat("OLD1", 4'hF, 1'b0);
    push_beat("OLD2", 4'hF, 1'b0);
    push_beat("OLD3", 4'hF, 1'b0);
    chk("pre_rst_valid", 64'(out_tvalid), 64'(1));
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_valid", 64'(out_tvalid), 64'(0));
    chk("async_ready", 64'(in_tready), 64'(0));
    chk("async_fill", 64'(fill_level), 64'(0));
    chk("async_data", 64'(out_tdata), 64'(0));
    chk("async_hf", 64'(flag_hf), 64'(0));
    q.delete();
    m_ready = 1'b0;
    cycle();
    cycle();
    aresetn = 1'b1;
    cycle();
    push_beat("NEW1", 4'hF, 1'b1);
    first = out_tdata;
    chk("post_rst_first", 64'(first), 64'("NEW1"));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
